pe_mem_responder: RTL

- Memory-side responder for the PE core's line-memory port (mem_req / mem_addr / mem_data / mem_ack).
- Accepts one 256-bit line read or write at a time and holds it in a local SRAM-style array.
- Returns mem_ack after a programmable latency.
- Serves as the L2/backing-store model and as the synthesizable scratch memory behind a PE in small configurations.

---
 rtl/pe_mem_pkg.sv | 32 +++
 rtl/pe_line_ram.sv | 30 +++
 rtl/pe_mem_responder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pe_mem_pkg.sv
// Shared constants, FSM encoding and address decode for the PE line-memory responder.
// Pure declarations: no latency, no flow control.
package pe_mem_pkg;

    localparam int LINE_BYTES    = 32;
    localparam int LINE_OFFSET_W = $clog2(LINE_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [31:0] idx;
        logic        oor;
    } line_loc_t;

    // Unsigned wrap of addr-base is harmless: addr<base is flagged explicitly.
    function automatic line_loc_t line_index(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input int          off_w,
                                             input int          depth);
        line_loc_t   loc;
        logic [31:0] offset;
        offset  = addr - base;
        loc.idx = offset >> off_w;
        loc.oor = (addr < base) || (loc.idx >= 32'(depth));
        return loc;
    endfunction

endpackage

// File: rtl/pe_line_ram.sv
// DEPTH x LINE_WIDTH line store: byte-enabled synchronous write, combinational read.
// Single write per cycle, no backpressure; kept standalone so a vendor macro can replace it.
module pe_line_ram #(
    parameter int LINE_WIDTH = 256,
    parameter int DEPTH      = 64
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [$clog2(DEPTH)-1:0]  waddr,
    input  logic [LINE_WIDTH/8-1:0]   be,
    input  logic [LINE_WIDTH-1:0]     wdata,
    input  logic [$clog2(DEPTH)-1:0]  raddr,
    output logic [LINE_WIDTH-1:0]     rdata
);

    logic [LINE_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < LINE_WIDTH / 8; b++) begin
                if (be[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pe_mem_responder.sv
// Memory-side responder for the PE line port: one 256-bit line read/write at a time.
// mem_ack pulses LATENCY cycles after acceptance; requests are only taken in IDLE.
module pe_mem_responder
    import pe_mem_pkg::*;
#(
    parameter int          LINE_WIDTH = LINE_BYTES * 8,
    parameter int          DEPTH      = 64,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_req,
    input  logic                    mem_we,
    input  logic [31:0]             mem_addr,
    input  logic [LINE_WIDTH/8-1:0] mem_be,
    input  logic [LINE_WIDTH-1:0]   mem_wdata,
    output logic [LINE_WIDTH-1:0]   mem_rdata,
    output logic                    mem_ack,
    output logic                    mem_err,
    output logic                    busy,
    output logic [15:0]             req_count
);

    localparam int LB    = LINE_WIDTH / 8;
    localparam int OFF_W = $clog2(LB);
    localparam int IDX_W = $clog2(DEPTH);

    state_t                state, state_nx;
    logic [3:0]            cnt, cnt_nx;
    logic                  we_q, oor_q;
    logic [IDX_W-1:0]      idx_q;
    logic [LB-1:0]         be_q;
    logic [LINE_WIDTH-1:0] wdata_q;

    line_loc_t             loc;
    logic                  cur_we, cur_oor;
    logic [IDX_W-1:0]      cur_idx;
    logic [LB-1:0]         cur_be;
    logic [LINE_WIDTH-1:0] cur_wdata;
    logic                  enter_resp, ram_we;
    logic [LINE_WIDTH-1:0] ram_rdata;
    logic                  unused_idx_hi;

    assign loc           = line_index(mem_addr, BASE_ADDR, OFF_W, DEPTH);
    assign unused_idx_hi = ^loc.idx[31:IDX_W];

    // With LATENCY=1 the RESP edge is the accepting edge, so the RAM must see live inputs.
    always_comb begin
        if (state == IDLE) begin
            cur_we    = mem_we;
            cur_oor   = loc.oor;
            cur_idx   = loc.idx[IDX_W-1:0];
            cur_be    = mem_be;
            cur_wdata = mem_wdata;
        end else begin
            cur_we    = we_q;
            cur_oor   = oor_q;
            cur_idx   = idx_q;
            cur_be    = be_q;
            cur_wdata = wdata_q;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    cnt_nx   = 4'(LATENCY - 1);
                    state_nx = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign enter_resp = (state_nx == RESP);
    assign ram_we     = enter_resp && cur_we && !cur_oor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mem_rdata <= '0;
            req_count <= 16'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (enter_resp && !cur_we) begin
                mem_rdata <= cur_oor ? '0 : ram_rdata;
            end
            if (state == RESP) begin
                req_count <= req_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && mem_req) begin
            we_q    <= mem_we;
            oor_q   <= loc.oor;
            idx_q   <= loc.idx[IDX_W-1:0];
            be_q    <= mem_be;
            wdata_q <= mem_wdata;
        end
    end

    assign mem_ack = (state == RESP);
    assign mem_err = mem_ack && oor_q;
    assign busy    = (state != IDLE);

    pe_line_ram #(
        .LINE_WIDTH (LINE_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (cur_idx),
        .be    (cur_be),
        .wdata (cur_wdata),
        .raddr (cur_idx),
        .rdata (ram_rdata)
    );

endmodule
